// File: rtl/delayed_branch_ctrl_if.sv
// Delayed-branch controller bus: enqueue, flag resolve and next-PC select.
// master drives the branch-decode/flag side, slave is the controller.
interface delayed_branch_ctrl_if #(
    parameter int AW = 9
);
    logic          stall_in;
    logic          enq_valid;
    logic [AW-1:0] enq_dest;
    logic [2:0]    enq_cond;
    logic          flags_valid;
    logic          N;
    logic          V;
    logic          Z;
    logic [AW-1:0] bgu_pc_next;
    logic [AW-1:0] pc_out;
    logic          pc_we;
    logic          flush;
    logic          odd_target;
    logic          full;
    logic          busy;
    logic          overflow;

    modport master (
        output stall_in, enq_valid, enq_dest, enq_cond,
        output flags_valid, N, V, Z, bgu_pc_next,
        input  pc_out, pc_we, flush, odd_target,
        input  full, busy, overflow
    );

    modport slave (
        input  stall_in, enq_valid, enq_dest, enq_cond,
        input  flags_valid, N, V, Z, bgu_pc_next,
        output pc_out, pc_we, flush, odd_target,
        output full, busy, overflow
    );
endinterface

// File: rtl/delayed_branch_ctrl.sv
// In-order queue of delayed conditional branches; the oldest entry is
// resolved against stage-3 flags and a taken one redirects and flushes.
module delayed_branch_ctrl #(
    parameter int DEPTH        = 2,
    parameter int AW           = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    delayed_branch_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_REDIRECT
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_dest [DEPTH];
    logic [2:0]    r_cond [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [FW-1:0] r_fcnt;
    logic [AW-1:0] r_target;
    logic          r_flush;
    logic          r_odd;
    logic          r_ovf;

    logic          w_run;
    logic          w_taken;
    logic          w_resolve;
    logic          w_take;
    logic          w_pop;
    logic          w_full;
    logic          w_enq;
    logic          w_push;
    logic          w_ovf;
    logic [CW-1:0] w_count_nxt;
    logic [AW-1:0] w_head_dest;

    function automatic logic cond_eval(
        input logic [2:0] c,
        input logic       n,
        input logic       v,
        input logic       z
    );
        logic l;
        l = n ^ v;
        case (c)
            3'd0:    cond_eval = 1'b0;
            3'd1:    cond_eval = 1'b1;
            3'd2:    cond_eval = z;
            3'd3:    cond_eval = ~z;
            3'd4:    cond_eval = l;
            3'd5:    cond_eval = l | z;
            3'd6:    cond_eval = ~z & ~l;
            default: cond_eval = ~l;
        endcase
    endfunction

    assign w_run       = ~bus.stall_in;
    assign w_head_dest = r_dest[r_rd];
    assign w_taken     = cond_eval(r_cond[r_rd], bus.N, bus.V, bus.Z);
    assign w_resolve   = w_run && r_state == S_PENDING && bus.flags_valid;
    assign w_take      = w_resolve && w_taken;
    assign w_pop       = w_resolve && !w_taken;
    assign w_full      = r_count == CW'(DEPTH);
    // A taken resolve kills any same-cycle push: it is on the wrong path.
    assign w_enq       = w_run && r_state != S_REDIRECT
                         && bus.enq_valid && !w_take;
    assign w_push      = w_enq && (!w_full || w_pop);
    assign w_ovf       = w_enq && w_full && !w_pop;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd     <= '0;
            r_wr     <= '0;
            r_count  <= '0;
            r_fcnt   <= '0;
            r_target <= '0;
            r_flush  <= 1'b0;
            r_odd    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_run) begin
            if (w_push) begin
                r_dest[r_wr] <= bus.enq_dest;
                r_cond[r_wr] <= bus.enq_cond;
                r_wr         <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            if (w_ovf)
                r_ovf <= 1'b1;
            r_count <= w_count_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (w_push)
                        r_state <= S_PENDING;
                end
                S_PENDING: begin
                    if (w_take) begin
                        r_rd     <= '0;
                        r_wr     <= '0;
                        r_count  <= '0;
                        r_target <= {w_head_dest[AW-1:1], 1'b0};
                        r_odd    <= w_head_dest[0];
                        r_flush  <= 1'b1;
                        r_fcnt   <= '0;
                        r_state  <= S_REDIRECT;
                    end else if (w_count_nxt == '0) begin
                        r_state <= S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    if (r_fcnt == FW'(FLUSH_CYCLES - 1)) begin
                        r_flush <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pc_out     = (r_state == S_REDIRECT) ? r_target
                                                    : bus.bgu_pc_next;
    assign bus.pc_we      = w_run && (r_state != S_REDIRECT
                                      || r_fcnt == '0);
    assign bus.flush      = r_flush;
    assign bus.odd_target = r_odd;
    assign bus.full       = w_full;
    assign bus.busy       = r_state != S_IDLE || r_count != '0;
    assign bus.overflow   = r_ovf;
endmodule
